// File: rtl/hazard_unit.sv
// hazard_unit: EX-stage operand forwarding selects plus forwarding statistics.
//
// Ports:
//   clk, rst               - rising-edge clock, synchronous active-high reset
//   RegWriteM, RegWriteW   - MEM / WB stage instruction writes the register file
//   RS1E, RS2E             - EX-stage source register indices
//   RDM, RDW               - MEM / WB stage destination register indices
//   ForwardAE, ForwardBE   - operand selects (00 regfile, 01 WB, 10 MEM), combinational
//   FwdMemCnt, FwdWbCnt    - saturating counts of cycles forwarding from MEM / WB
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [4:0]  RS1E,
  input  logic [4:0]  RS2E,
  input  logic [4:0]  RDM,
  input  logic [4:0]  RDW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [15:0] FwdMemCnt,
  output logic [15:0] FwdWbCnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] fwd_mem_cnt_q, fwd_mem_cnt_d;
  logic [CNT_W-1:0] fwd_wb_cnt_q,  fwd_wb_cnt_d;
  logic             any_mem_c;
  logic             any_wb_c;

  // Select for one source; MEM wins over WB because it holds the newer value,
  // and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             rst_i,
    input logic [REG_W-1:0] rs,
    input logic             rw_m,
    input logic [REG_W-1:0] rd_m,
    input logic             rw_w,
    input logic [REG_W-1:0] rd_w
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (rst_i) begin
      sel = SEL_RF;
    end else if (rw_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = SEL_MEM;
    end else if (rw_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  // Forwarding selects and next counter values.
  always_comb begin
    ForwardAE     = fwd_sel(rst, RS1E, RegWriteM, RDM, RegWriteW, RDW);
    ForwardBE     = fwd_sel(rst, RS2E, RegWriteM, RDM, RegWriteW, RDW);
    any_mem_c     = (ForwardAE == SEL_MEM) || (ForwardBE == SEL_MEM);
    any_wb_c      = (ForwardAE == SEL_WB)  || (ForwardBE == SEL_WB);
    fwd_mem_cnt_d = fwd_mem_cnt_q;
    fwd_wb_cnt_d  = fwd_wb_cnt_q;
    if (any_mem_c && (fwd_mem_cnt_q != CNT_MAX)) begin
      fwd_mem_cnt_d = fwd_mem_cnt_q + CNT_W'(1);
    end
    if (any_wb_c && (fwd_wb_cnt_q != CNT_MAX)) begin
      fwd_wb_cnt_d = fwd_wb_cnt_q + CNT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_mem_cnt_q <= '0;
      fwd_wb_cnt_q  <= '0;
    end else begin
      fwd_mem_cnt_q <= fwd_mem_cnt_d;
      fwd_wb_cnt_q  <= fwd_wb_cnt_d;
    end
  end

  assign FwdMemCnt = fwd_mem_cnt_q;
  assign FwdWbCnt  = fwd_wb_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors with hand-computed expectations for hazard_unit.
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        RegWriteW;
  logic [4:0]  RS1E;
  logic [4:0]  RS2E;
  logic [4:0]  RDM;
  logic [4:0]  RDW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [15:0] FwdMemCnt;
  logic [15:0] FwdWbCnt;

  int unsigned n_vec;
  int unsigned n_err;

  hazard_unit u_dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .RS1E      (RS1E),
    .RS2E      (RS2E),
    .RDM       (RDM),
    .RDW       (RDW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .FwdMemCnt (FwdMemCnt),
    .FwdWbCnt  (FwdWbCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one input vector, wait 1 ns, check both selects.
  task automatic vec(input string tag,
                     input logic rwm, input logic rww,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rdm, input logic [4:0] rdw,
                     input logic [1:0] exp_a, input logic [1:0] exp_b);
    RegWriteM = rwm;
    RegWriteW = rww;
    RS1E      = rs1;
    RS2E      = rs2;
    RDM       = rdm;
    RDW       = rdw;
    #1;
    check({tag, "_AE"}, 16'(ForwardAE), 16'(exp_a));
    check({tag, "_BE"}, 16'(ForwardBE), 16'(exp_b));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset gates selects even with matching inputs.
    rst = 1'b1;
    vec("rst_gate", 1'b1, 1'b1, 5'd1, 5'd2, 5'd1, 5'd2, 2'b00, 2'b00);
    @(posedge clk); #1;
    check("rst_mem_cnt", FwdMemCnt, 16'h0000);
    check("rst_wb_cnt",  FwdWbCnt,  16'h0000);

    rst = 1'b0;
    vec("no_match",   1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4, 2'b00, 2'b00);
    vec("mem_a",      1'b1, 1'b0, 5'd1, 5'd2, 5'd1, 5'd4, 2'b10, 2'b00);
    vec("wb_b",       1'b0, 1'b1, 5'd1, 5'd2, 5'd1, 5'd2, 2'b00, 2'b01);
    vec("src_x0",     1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 5'd2, 2'b00, 2'b00);
    vec("x0_never",   1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00);
    vec("mem_a_wb_b", 1'b1, 1'b1, 5'd1, 5'd2, 5'd1, 5'd2, 2'b10, 2'b01);
    vec("mem_prio",   1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 2'b10, 2'b10);
    vec("wb_a",       1'b0, 1'b1, 5'd1, 5'd3, 5'd3, 5'd1, 2'b01, 2'b00);
    vec("mem_b",      1'b1, 1'b0, 5'd3, 5'd2, 5'd2, 5'd3, 2'b00, 2'b10);
    vec("wb_a_mem_b", 1'b1, 1'b1, 5'd2, 5'd1, 5'd1, 5'd2, 2'b01, 2'b10);

    // Counter section: start from a clean reset.
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2_mem_cnt", FwdMemCnt, 16'h0000);
    check("rst2_wb_cnt",  FwdWbCnt,  16'h0000);
    rst = 1'b0;
    vec("cnt_setup", 1'b1, 1'b1, 5'd1, 5'd2, 5'd1, 5'd2, 2'b10, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    check("cnt3_mem", FwdMemCnt, 16'd3);
    check("cnt3_wb",  FwdWbCnt,  16'd3);

    // Both operands from MEM still count once per cycle.
    vec("both_mem", 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 5'd2, 2'b10, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    check("cnt_once_mem", FwdMemCnt, 16'd5);
    check("cnt_once_wb",  FwdWbCnt,  16'd3);

    // Saturation: a wrapping counter would read 5 + 65540 - 65536 = 9.
    repeat (65540) @(posedge clk);
    #1;
    check("sat_mem", FwdMemCnt, 16'hFFFF);
    check("sat_wb",  FwdWbCnt,  16'd3);

    // Mid-operation reset.
    rst = 1'b1;
    #1;
    check("mid_rst_AE", 16'(ForwardAE), 16'h0000);
    check("mid_rst_BE", 16'(ForwardBE), 16'h0000);
    @(posedge clk); #1;
    check("mid_rst_mem", FwdMemCnt, 16'h0000);
    check("mid_rst_wb",  FwdWbCnt,  16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
